// File: rtl/snd_ctrl_pkg.sv
// Shared types and constants for the SPI slave transmit-side size/byte controller.
package snd_ctrl_pkg;

  localparam int unsigned SIZE_W_DEF  = 16;
  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned BYTE_IDX_W  = 2;

  // Index of the final byte within a fetched word.
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    SND_IDLE  = 2'd0,
    SND_FETCH = 2'd1,
    SND_SHIFT = 2'd2
  } snd_state_e;

endpackage

// File: rtl/snd_ctrl_if.sv
// Word-fetch (TX buffer) and byte-stream (shift engine) handshakes of the send controller.
interface snd_ctrl_if;

  logic        wd_req;
  logic        wd_ack;
  logic [31:0] wd_data;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        tx_rdy;

  // Controller side
  modport master (
    output wd_req,
    input  wd_ack,
    input  wd_data,
    output tx_byte,
    output tx_vld,
    input  tx_rdy
  );

  // TX buffer / shift engine side
  modport slave (
    input  wd_req,
    output wd_ack,
    output wd_data,
    input  tx_byte,
    input  tx_vld,
    output tx_rdy
  );

endinterface

// File: rtl/snd_ctrl_word_buf.sv
// Holds the fetched 32-bit word and selects the current byte by index.
module snd_word_buf
  import snd_ctrl_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [31:0]           wd_data_i,
  input  logic                  idx_clr_i,
  input  logic                  idx_inc_i,
  output logic [BYTE_IDX_W-1:0] idx_o,
  output logic [7:0]            byte_o
);

  logic [31:0]           word_q;
  logic [BYTE_IDX_W-1:0] idx_q;
  logic [BYTE_IDX_W-1:0] sel;

  // Word register: captured on a granted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= wd_data_i;
    end
  end

  // Byte index: clear wins over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (idx_clr_i) begin
      idx_q <= '0;
    end else if (idx_inc_i) begin
      idx_q <= idx_q + BYTE_IDX_W'(1);
    end
  end

  // Byte mux; MSB-first order just walks the lanes in reverse
  always_comb begin
    sel = (LSB_FIRST != 0) ? idx_q : ~idx_q;
    case (sel)
      2'd0:    byte_o = word_q[7:0];
      2'd1:    byte_o = word_q[15:8];
      2'd2:    byte_o = word_q[23:16];
      default: byte_o = word_q[31:24];
    endcase
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/snd_ctrl.sv
// Transmit-side size/byte controller: loads a byte count, fetches words and streams bytes.
module snd_ctrl
  import snd_ctrl_pkg::*;
#(
  parameter int SIZE_W    = SIZE_W_DEF,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE_W-1:0] rd_size,
  input  logic [SIZE_W-1:0] cmd_extend,
  input  logic              snd_rd_d,
  input  logic              snd_bc_d,
  input  logic              snd_clr,
  snd_ctrl_if.master        bus,
  output logic [SIZE_W-1:0] snd_size,
  output logic              snd_last,
  output logic              snd_done,
  output logic              snd_busy
);

  snd_state_e            state_q, state_d;
  logic [SIZE_W-1:0]     size_q, size_d;
  logic                  word_load;
  logic                  idx_clr;
  logic                  idx_inc;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [7:0]            cur_byte;
  logic                  wd_req_o;
  logic                  tx_vld_o;
  logic                  busy_o;

  snd_word_buf #(
    .LSB_FIRST (LSB_FIRST)
  ) u_word_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (word_load),
    .wd_data_i (bus.wd_data),
    .idx_clr_i (idx_clr),
    .idx_inc_i (idx_inc),
    .idx_o     (byte_idx),
    .byte_o    (cur_byte)
  );

  // State and remaining-size registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SND_IDLE;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
    end
  end

  // Next state and size: clear > read load > broadcast load > transfer
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    word_load = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    if (snd_clr) begin
      state_d = SND_IDLE;
      size_d  = '0;
      idx_clr = 1'b1;
    end else if (snd_rd_d) begin
      size_d  = rd_size;
      idx_clr = 1'b1;
      state_d = (rd_size != '0) ? SND_FETCH : SND_IDLE;
    end else if (snd_bc_d) begin
      size_d  = cmd_extend;
      idx_clr = 1'b1;
      state_d = (cmd_extend != '0) ? SND_FETCH : SND_IDLE;
    end else begin
      case (state_q)
        SND_FETCH: begin
          if (bus.wd_ack) begin
            word_load = 1'b1;
            idx_clr   = 1'b1;
            state_d   = SND_SHIFT;
          end
        end
        SND_SHIFT: begin
          // SHIFT is only ever entered with size >= 1, so this cannot underflow
          if (bus.tx_rdy) begin
            size_d  = size_q - SIZE_W'(1);
            idx_inc = 1'b1;
            if (size_q == SIZE_W'(1)) begin
              state_d = SND_IDLE;
            end else if (byte_idx == LAST_BYTE_IDX) begin
              state_d = SND_FETCH;
            end
          end
        end
        default: state_d = SND_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    wd_req_o = (state_q == SND_FETCH);
    tx_vld_o = (state_q == SND_SHIFT);
    busy_o   = (state_q != SND_IDLE);
  end

  assign bus.wd_req  = wd_req_o;
  assign bus.tx_vld  = tx_vld_o;
  assign bus.tx_byte = cur_byte;
  assign snd_size    = size_q;
  assign snd_done    = (size_q == '0);
  assign snd_last    = tx_vld_o && (size_q == SIZE_W'(1));
  assign snd_busy    = busy_o;

endmodule

// File: tb/tb_snd_ctrl.sv
// Directed self-checking bench for snd_ctrl (LSB-first and MSB-first instances).
module tb_snd_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] rd_size;
  logic [15:0] cmd_extend;
  logic        snd_rd_d;
  logic        snd_bc_d;
  logic        snd_clr;
  logic [15:0] snd_size,  snd_size2;
  logic        snd_last,  snd_last2;
  logic        snd_done,  snd_done2;
  logic        snd_busy,  snd_busy2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned acks   = 0;

  snd_ctrl_if bus ();
  snd_ctrl_if bus2 ();

  // MSB-first twin sees exactly the same buffer/engine stimulus
  assign bus2.wd_ack  = bus.wd_ack;
  assign bus2.wd_data = bus.wd_data;
  assign bus2.tx_rdy  = bus.tx_rdy;

  snd_ctrl #(.SIZE_W(16), .LSB_FIRST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_size    (rd_size),
    .cmd_extend (cmd_extend),
    .snd_rd_d   (snd_rd_d),
    .snd_bc_d   (snd_bc_d),
    .snd_clr    (snd_clr),
    .bus        (bus),
    .snd_size   (snd_size),
    .snd_last   (snd_last),
    .snd_done   (snd_done),
    .snd_busy   (snd_busy)
  );

  snd_ctrl #(.SIZE_W(16), .LSB_FIRST(0)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_size    (rd_size),
    .cmd_extend (cmd_extend),
    .snd_rd_d   (snd_rd_d),
    .snd_bc_d   (snd_bc_d),
    .snd_clr    (snd_clr),
    .bus        (bus2),
    .snd_size   (snd_size2),
    .snd_last   (snd_last2),
    .snd_done   (snd_done2),
    .snd_busy   (snd_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant one word fetch, waiting a bounded number of cycles for the request
  task automatic fetch(input string tag, input logic [31:0] d);
    int unsigned n = 0;
    while (bus.wd_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {31'b0, bus.wd_req}, 32'd1);
    bus.wd_ack  = 1'b1;
    bus.wd_data = d;
    step();
    bus.wd_ack  = 1'b0;
    acks++;
  endtask

  // Check the presented byte (both byte orders), then let one cycle pass
  task automatic byte_chk(input string tag, input logic [7:0] b, input logic [7:0] b2,
                          input logic [15:0] sz, input logic last);
    chk({tag, "_vld"},  {31'b0, bus.tx_vld}, 32'd1);
    chk({tag, "_byte"}, {24'b0, bus.tx_byte}, {24'b0, b});
    chk({tag, "_msb"},  {24'b0, bus2.tx_byte}, {24'b0, b2});
    chk({tag, "_size"}, {16'b0, snd_size}, {16'b0, sz});
    chk({tag, "_last"}, {31'b0, snd_last}, {31'b0, last});
    step();
  endtask

  logic [7:0] exp_lsb [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] exp_msb [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

  initial begin
    int unsigned req_seen;
    rst_n = 1'b0; rd_size = '0; cmd_extend = '0;
    snd_rd_d = 1'b0; snd_bc_d = 1'b0; snd_clr = 1'b0;
    bus.wd_ack = 1'b0; bus.wd_data = '0; bus.tx_rdy = 1'b0;
    step(); step();

    // Reset state
    chk("rst_size", {16'b0, snd_size}, 32'd0);
    chk("rst_done", {31'b0, snd_done}, 32'd1);
    chk("rst_last", {31'b0, snd_last}, 32'd0);
    chk("rst_busy", {31'b0, snd_busy}, 32'd0);
    chk("rst_req",  {31'b0, bus.wd_req}, 32'd0);
    chk("rst_vld",  {31'b0, bus.tx_vld}, 32'd0);
    chk("rst_byte", {24'b0, bus.tx_byte}, 32'd0);
    rst_n = 1'b1;
    bus.tx_rdy = 1'b1;

    // 1: 8-byte read, both byte orders
    rd_size = 16'd8; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    chk("t1_req",  {31'b0, bus.wd_req}, 32'd1);
    chk("t1_size", {16'b0, snd_size}, 32'd8);
    chk("t1_busy", {31'b0, snd_busy}, 32'd1);
    chk("t1_vld0", {31'b0, bus.tx_vld}, 32'd0);
    fetch("t1_f0", 32'h44332211);
    for (int i = 0; i < 4; i++)
      byte_chk("t1_b", exp_lsb[i], exp_msb[i], 16'(8 - i), 1'b0);
    chk("t1_gap_vld", {31'b0, bus.tx_vld}, 32'd0);
    chk("t1_gap_req", {31'b0, bus.wd_req}, 32'd1);
    fetch("t1_f1", 32'h88776655);
    for (int i = 4; i < 8; i++)
      byte_chk("t1_b", exp_lsb[i], exp_msb[i], 16'(8 - i), (i == 7));
    chk("t1_done",  {31'b0, snd_done}, 32'd1);
    chk("t1_done2", {31'b0, snd_done2}, 32'd1);
    chk("t1_busy0", {31'b0, snd_busy}, 32'd0);
    chk("t1_req0",  {31'b0, bus.wd_req}, 32'd0);
    chk("t1_vld_end", {31'b0, bus.tx_vld}, 32'd0);

    // Ack without request is ignored
    bus.wd_ack = 1'b1; bus.wd_data = 32'hDEADBEEF; step(); bus.wd_ack = 1'b0;
    chk("ign_busy", {31'b0, snd_busy}, 32'd0);
    chk("ign_vld",  {31'b0, bus.tx_vld}, 32'd0);

    // 2: broadcast of 5 bytes, exactly two fetches
    acks = 0;
    cmd_extend = 16'd5; snd_bc_d = 1'b1; step(); snd_bc_d = 1'b0;
    fetch("t2_f0", 32'h44332211);
    for (int i = 0; i < 4; i++)
      byte_chk("t2_b", exp_lsb[i], exp_msb[i], 16'(5 - i), 1'b0);
    fetch("t2_f1", 32'h88776655);
    byte_chk("t2_b4", 8'h55, 8'h88, 16'd1, 1'b1);
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wd_req === 1'b1) req_seen++;
      step();
    end
    chk("t2_no_refetch", req_seen, 32'd0);
    chk("t2_acks", acks, 32'd2);
    chk("t2_done", {31'b0, snd_done}, 32'd1);

    // 3: backpressure on byte 2, then restart by a new load
    rd_size = 16'd8; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    fetch("t3_f0", 32'h44332211);
    byte_chk("t3_b0", 8'h11, 8'h44, 16'd8, 1'b0);
    bus.tx_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_byte", {24'b0, bus.tx_byte}, 32'h22);
      chk("t3_hold_vld",  {31'b0, bus.tx_vld}, 32'd1);
      chk("t3_hold_size", {16'b0, snd_size}, 32'd7);
      step();
    end
    bus.tx_rdy = 1'b1;
    byte_chk("t3_b1", 8'h22, 8'h33, 16'd7, 1'b0);
    byte_chk("t3_b2", 8'h33, 8'h22, 16'd6, 1'b0);
    rd_size = 16'd2; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    chk("t3_rl_vld",  {31'b0, bus.tx_vld}, 32'd0);
    chk("t3_rl_req",  {31'b0, bus.wd_req}, 32'd1);
    chk("t3_rl_size", {16'b0, snd_size}, 32'd2);
    fetch("t3_f1", 32'hCAFEF00D);
    byte_chk("t3_p0", 8'h0D, 8'hCA, 16'd2, 1'b0);
    byte_chk("t3_p1", 8'hF0, 8'hFE, 16'd1, 1'b1);
    chk("t3_p_done", {31'b0, snd_done}, 32'd1);
    chk("t3_p_req",  {31'b0, bus.wd_req}, 32'd0);

    // 4: abort after two bytes
    rd_size = 16'd8; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    fetch("t4_f0", 32'h44332211);
    byte_chk("t4_b0", 8'h11, 8'h44, 16'd8, 1'b0);
    byte_chk("t4_b1", 8'h22, 8'h33, 16'd7, 1'b0);
    snd_clr = 1'b1; step(); snd_clr = 1'b0;
    chk("t4_vld",  {31'b0, bus.tx_vld}, 32'd0);
    chk("t4_req",  {31'b0, bus.wd_req}, 32'd0);
    chk("t4_size", {16'b0, snd_size}, 32'd0);
    chk("t4_done", {31'b0, snd_done}, 32'd1);
    chk("t4_busy", {31'b0, snd_busy}, 32'd0);

    // 5: load priority
    rd_size = 16'd3; cmd_extend = 16'd9;
    snd_rd_d = 1'b1; snd_bc_d = 1'b1; step(); snd_rd_d = 1'b0; snd_bc_d = 1'b0;
    chk("t5_size", {16'b0, snd_size}, 32'd3);
    chk("t5_req",  {31'b0, bus.wd_req}, 32'd1);
    snd_rd_d = 1'b1; snd_bc_d = 1'b1; snd_clr = 1'b1; step();
    snd_rd_d = 1'b0; snd_bc_d = 1'b0; snd_clr = 1'b0;
    chk("t5_clr_size", {16'b0, snd_size}, 32'd0);
    chk("t5_clr_done", {31'b0, snd_done}, 32'd1);
    chk("t5_clr_req",  {31'b0, bus.wd_req}, 32'd0);

    // 6: zero load, maximum load, async reset mid-SHIFT
    rd_size = 16'd0; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    chk("t6_z_busy", {31'b0, snd_busy}, 32'd0);
    chk("t6_z_req",  {31'b0, bus.wd_req}, 32'd0);
    chk("t6_z_done", {31'b0, snd_done}, 32'd1);
    step();
    chk("t6_z_req2", {31'b0, bus.wd_req}, 32'd0);
    rd_size = 16'hFFFF; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    chk("t6_max_size", {16'b0, snd_size}, 32'h0000FFFF);
    chk("t6_max_req",  {31'b0, bus.wd_req}, 32'd1);
    snd_clr = 1'b1; step(); snd_clr = 1'b0;
    rd_size = 16'd8; snd_rd_d = 1'b1; step(); snd_rd_d = 1'b0;
    fetch("t6_f0", 32'h44332211);
    chk("t6_pre_vld", {31'b0, bus.tx_vld}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ar_vld",   {31'b0, bus.tx_vld}, 32'd0);
    chk("t6_ar_req",   {31'b0, bus.wd_req}, 32'd0);
    chk("t6_ar_size",  {16'b0, snd_size}, 32'd0);
    chk("t6_ar_done",  {31'b0, snd_done}, 32'd1);
    chk("t6_ar_last",  {31'b0, snd_last}, 32'd0);
    chk("t6_ar_busy",  {31'b0, snd_busy}, 32'd0);
    chk("t6_ar_byte",  {24'b0, bus.tx_byte}, 32'd0);
    chk("t6_ar_byte2", {24'b0, bus2.tx_byte}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
